prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/loader_csum.sv | 27 ++
 rtl/prog_loader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum stage is built when PROG_LOADER_CSUM_EN is defined.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    COUNT,
    HI,
    LO,
    WR,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int ROM_AW = 8;
  localparam int INST_W = 15;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte link: valid/ready handshake into the loader.
// master = host side, slave = loader side.
interface prog_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/loader_csum.sv
// 8-bit modulo-256 byte accumulator with clear/add.
// zero reports whether acc + din would be 0x00.
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic       zero
);

  logic [7:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + din;
    end
  end

  // Look-ahead so the final checksum byte can be judged as it transfers.
  assign zero = (8'(acc + din) == 8'h00);

endmodule

// File: rtl/prog_loader.sv
// Host-link instruction-ROM loader: header/addr/count/words(/checksum).
// Checksum byte and check are present when PROG_LOADER_CSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      link,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [INST_W-1:0] rom_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t     state;
  logic [8:0] cnt;
  logic [6:0] hi_q;
  logic [7:0] b;
  logic       xfer;

  assign b = link.in_data;
  assign link.in_ready = (state != WR);
  assign xfer = link.in_valid && link.in_ready;

`ifdef PROG_LOADER_CSUM_EN
  logic csum_clr;
  logic csum_add;
  logic csum_ok;

  assign csum_clr = xfer && (b == HDR_BYTE) &&
                    (state inside {IDLE, DONE, ERR});
  assign csum_add = xfer &&
                    (state inside {ADDR, COUNT, HI, LO, CSUM});

  loader_csum u_csum (
    .clk  (clk),
    .reset(reset),
    .clr  (csum_clr),
    .add  (csum_add),
    .din  (b),
    .zero (csum_ok)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      rom_we   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (state == WR) begin
      rom_we   <= 1'b0;
      rom_addr <= rom_addr + 1'b1;
      cnt      <= cnt - 9'd1;
      if (cnt == 9'd1) begin
`ifdef PROG_LOADER_CSUM_EN
        state    <= CSUM;
`else
        state    <= DONE;
        done     <= 1'b1;
        cpu_hold <= 1'b0;
`endif
      end else begin
        state <= HI;
      end
    end else if (xfer) begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (b == HDR_BYTE) begin
            state    <= ADDR;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        ADDR: begin
          rom_addr <= b;
          state    <= COUNT;
        end
        COUNT: begin
          cnt   <= (b == 8'h00) ? 9'd256 : {1'b0, b};
          state <= HI;
        end
        HI: begin
          if (b[7]) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            hi_q  <= b[6:0];
            state <= LO;
          end
        end
        LO: begin
          rom_data <= {hi_q, b};
          rom_we   <= 1'b1;
          state    <= WR;
        end
`ifdef PROG_LOADER_CSUM_EN
        CSUM: begin
          if (csum_ok) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
